// File: rtl/fetch_decode_buffer_pkg.sv
// Shared types and helpers for the fetch->decode instruction buffer.
// Entry layout, NOP encoding and the wrap-bit full test used by the buffer top.
package fetch_pkg;

    localparam int INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000000;
    localparam int PTR_MAX_W = 16;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc_plus_4;
    } fetch_entry_t;

    // Pointers arrive zero-extended; idx_w is the number of index bits below the wrap bit.
    function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] wr,
                                      input logic [PTR_MAX_W-1:0] rd,
                                      input int                   idx_w);
        logic [PTR_MAX_W-1:0] diff;
        logic                 idx_eq;
        logic                 wrap_ne;
        diff    = wr ^ rd;
        idx_eq  = 1'b1;
        wrap_ne = 1'b0;
        for (int b = 0; b < PTR_MAX_W; b++) begin
            if (b < idx_w)
                idx_eq = idx_eq & ~diff[b];
            else if (b == idx_w)
                wrap_ne = diff[b];
        end
        return idx_eq & wrap_ne;
    endfunction

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch/decode handshake bundle: master = fetch+decode side, slave = the buffer.
// Valid/ready on both sides plus flush and occupancy.
interface fetch_decode_buffer_if #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_pc_plus_4;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_pc_plus_4;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_instr, in_pc_plus_4, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc_plus_4, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc_plus_4, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc_plus_4, count
    );

endinterface

// File: rtl/fetch_decode_buffer_ptr.sv
// Wrapping FIFO pointer with wrap bit: increment enable, synchronous clear.
// Latency: new value visible after the edge. No backpressure; clear beats increment.
module fetch_buf_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)
            ptr_d = '0;
        else if (inc_i)
            ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_decode_buffer.sv
// Elastic fetch->decode buffer; push visible on out_* one cycle later (no bypass); flush empties it.
// Backpressure: in_ready = !full, independent of out_ready. Build macro FETCH_BUF_NOP_EN forces NOP bubbles.
module fetch_decode_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = INSTR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_decode_buffer_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PW    = IDX_W + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = ptr_full(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr), IDX_W);

    // Flush cancels both sides in the same cycle it is seen.
    assign push = bus.in_valid && !full  && !bus.flush;
    assign pop  = bus.out_ready && !empty && !bus.flush;

    fetch_buf_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (push),
        .clr_i (bus.flush),
        .ptr_o (wr_ptr)
    );

    fetch_buf_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (pop),
        .clr_i (bus.flush),
        .ptr_o (rd_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr[IDX_W-1:0]] <= '{instr: bus.in_instr, pc_plus_4: bus.in_pc_plus_4};
        end
    end

    assign head = mem_q[rd_ptr[IDX_W-1:0]];

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.count     = wr_ptr - rd_ptr;

`ifdef FETCH_BUF_NOP_EN
    assign bus.out_instr     = empty ? NOP_INSTR : head.instr;
    assign bus.out_pc_plus_4 = empty ? '0        : head.pc_plus_4;
`else
    // Stale while empty; decode qualifies with out_valid.
    assign bus.out_instr     = head.instr;
    assign bus.out_pc_plus_4 = head.pc_plus_4;
`endif

endmodule
